// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration path: sequencer states and
// register-table entry layout.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_DELAY,
        ST_XFER,
        ST_WAIT_END,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    localparam logic [15:0] LUT_DELAY_TAG = 16'hFFFF;

    localparam int unsigned LUT_DATA_LSB = 0;
    localparam int unsigned LUT_DATA_MSB = 7;
    localparam int unsigned LUT_SUB_LSB  = 8;
    localparam int unsigned LUT_SUB_MSB  = 23;

    function automatic logic is_delay_entry(input logic [23:0] entry);
        return entry[LUT_SUB_MSB:LUT_SUB_LSB] == LUT_DELAY_TAG;
    endfunction

endpackage

// File: rtl/sccb_step_gen.sv
// Free-running bit-step divider: one-cycle step strobe at count 0 and an SCL
// pulse that is high for the middle half of each step period.
module sccb_step_gen #(
    parameter int unsigned CLK_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    output logic step_en,
    output logic scl
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SCL_RISE = CW'(CLK_DIV / 4);
    localparam logic [CW-1:0] SCL_FALL = CW'((3 * CLK_DIV) / 4);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          scl_q, scl_d;

    // Outputs are decoded from the next count so they line up with cnt_q.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        en_d  = (cnt_d == '0);
        scl_d = (cnt_d >= SCL_RISE) && (cnt_d < SCL_FALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            scl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            scl_q <= scl_d;
        end
    end

    assign step_en = en_q;
    assign scl     = scl_q;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera register table after power-up and issues one SCCB write per
// entry, with retry on NACK/timeout and support for in-table delay entries.
module sccb_cfg_sequencer
    import sccb_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 500,
    parameter int unsigned INIT_DELAY    = 1000000,
    parameter int unsigned LUT_SIZE      = 256,
    parameter int unsigned LUT_AW        = 8,
    parameter logic [7:0]  SLAVE_ADDR    = 8'h78,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned TIMEOUT_STEPS = 100,
    parameter int unsigned DLY_UNIT      = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    output logic [LUT_AW-1:0] lut_index,
    input  logic [23:0]       lut_data,
    output logic              i2c_en,
    output logic              i2c_clk,
    output logic [39:0]       i2c_wdata,
    output logic              wr,
    output logic              trans,
    input  logic              ack,
    input  logic              i2c_end,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [LUT_AW-1:0] err_index
);

    localparam int unsigned PW = $clog2(INIT_DELAY + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_STEPS + 1);
    localparam int unsigned DW = 8 + $clog2(DLY_UNIT) + 1;

    localparam logic [LUT_AW-1:0] LAST_IDX = LUT_AW'(LUT_SIZE - 1);
    localparam logic [PW-1:0]     PWR_LAST = PW'(INIT_DELAY - 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_STEPS - 1);
    localparam logic [7:0]        RD_ADDR  = SLAVE_ADDR | 8'h01;

    logic step_en;
    logic scl;

    sccb_step_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_step_gen (
        .clk    (clk),
        .rst    (rst),
        .step_en(step_en),
        .scl    (scl)
    );

    cfg_state_e        state_q, state_d;
    logic [LUT_AW-1:0] idx_q, idx_d;
    logic [39:0]       wdata_q, wdata_d;
    logic              trans_q, trans_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LUT_AW-1:0] err_idx_q, err_idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic [PW-1:0]     pwr_q, pwr_d;
    logic              fail_q, fail_d;
    logic              gap_en_q, gap_en_d;
    logic              advance;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        trans_d   = trans_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        dly_d     = dly_q;
        pwr_d     = pwr_q;
        fail_d    = fail_q;
        gap_en_d  = gap_en_q;
        advance   = 1'b0;

        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_q == PWR_LAST) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    pwr_d = pwr_q + 1'b1;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                wdata_d = {RD_ADDR, SLAVE_ADDR, lut_data};
                if (is_delay_entry(lut_data)) begin
                    dly_d   = DW'(lut_data[LUT_DATA_MSB:LUT_DATA_LSB]) * DW'(DLY_UNIT);
                    state_d = ST_DELAY;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) begin
                    advance = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_XFER: begin
                trans_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (i2c_end) begin
                    fail_d   = ack;
                    trans_d  = 1'b0;
                    gap_en_d = 1'b0;
                    state_d  = ST_GAP;
                end else if (step_en) begin
                    if (tmo_q == TMO_LAST) begin
                        fail_d   = 1'b1;
                        trans_d  = 1'b0;
                        gap_en_d = 1'b0;
                        state_d  = ST_GAP;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // The engine clears its bit counter on a step seen with trans low.
                if (step_en) begin
                    gap_en_d = 1'b1;
                end
                if (gap_en_q && !i2c_end) begin
                    if (!fail_q) begin
                        advance = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        busy_d    = 1'b0;
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (cfg_start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase

        if (advance) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PWR_WAIT;
            idx_q     <= '0;
            wdata_q   <= '0;
            trans_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            dly_q     <= '0;
            pwr_q     <= '0;
            fail_q    <= 1'b0;
            gap_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            trans_q   <= trans_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            dly_q     <= dly_d;
            pwr_q     <= pwr_d;
            fail_q    <= fail_d;
            gap_en_q  <= gap_en_d;
        end
    end

    assign lut_index = idx_q;
    assign i2c_en    = step_en;
    assign i2c_clk   = scl;
    assign i2c_wdata = wdata_q;
    assign wr        = 1'b1;
    assign trans     = trans_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = err_idx_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Randomized bench for sccb_cfg_sequencer: sync ROM, engine BFM and a
// transaction-level model of the expected write sequence.
module tb_sccb_cfg_sequencer;

    localparam int unsigned CLK_DIV       = 8;
    localparam int unsigned INIT_DELAY    = 20;
    localparam int unsigned LUT_SIZE      = 4;
    localparam int unsigned LUT_AW        = 2;
    localparam int unsigned MAX_RETRY     = 3;
    localparam int unsigned TIMEOUT_STEPS = 100;
    localparam int unsigned DLY_UNIT      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [LUT_AW-1:0] lut_index;
    logic [23:0]       lut_data = '0;
    logic              i2c_en, i2c_clk, wr, trans;
    logic [39:0]       i2c_wdata;
    logic              ack = 1'b0;
    logic              i2c_end = 1'b0;
    logic              cfg_busy, cfg_done, cfg_err;
    logic [LUT_AW-1:0] err_index;

    sccb_cfg_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .INIT_DELAY   (INIT_DELAY),
        .LUT_SIZE     (LUT_SIZE),
        .LUT_AW       (LUT_AW),
        .SLAVE_ADDR   (8'h78),
        .MAX_RETRY    (MAX_RETRY),
        .TIMEOUT_STEPS(TIMEOUT_STEPS),
        .DLY_UNIT     (DLY_UNIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .lut_index(lut_index),
        .lut_data (lut_data),
        .i2c_en   (i2c_en),
        .i2c_clk  (i2c_clk),
        .i2c_wdata(i2c_wdata),
        .wr       (wr),
        .trans    (trans),
        .ack      (ack),
        .i2c_end  (i2c_end),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [LUT_SIZE];
    always @(posedge clk) lut_data <= rom[lut_index];

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    int          nack [LUT_SIZE];
    bit          hang [LUT_SIZE];
    logic [39:0] exp_q [$];
    int          resp_q [$];
    logic [39:0] wlog [$];
    longint      rise_cyc [$];
    longint      gap_log [$];
    bit          exp_done, exp_err;
    int          exp_eidx;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected write sequence: each write entry is attempted until it is
    // acknowledged or MAX_RETRY re-attempts are used up; delay entries emit nothing.
    task automatic build_model();
        exp_q.delete(); resp_q.delete(); wlog.delete(); rise_cyc.delete(); gap_log.delete();
        exp_done = 1'b1; exp_err = 1'b0; exp_eidx = 0;
        for (int i = 0; i < LUT_SIZE; i++) begin
            if (rom[i][23:8] == 16'hFFFF) continue;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                exp_q.push_back({8'h79, 8'h78, rom[i]});
                if (a < nack[i]) resp_q.push_back(hang[i] ? 2 : 1);
                else begin
                    resp_q.push_back(0);
                    break;
                end
            end
            if (nack[i] > MAX_RETRY) begin
                exp_done = 1'b0; exp_err = 1'b1; exp_eidx = i;
                break;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < LUT_SIZE; i++) begin
            nack[i] = 0; hang[i] = 1'b0;
        end
    endtask

    task automatic load_spec_rom();
        rom[0] = 24'h3008_82; rom[1] = 24'hFFFF_02; rom[2] = 24'h3103_11; rom[3] = 24'h4300_30;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (cfg_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, cfg_busy, 0);
        repeat (6 * CLK_DIV) @(negedge clk);
    endtask

    task automatic check_end(input string name);
        chk({name, "_model_drained"}, exp_q.size(), 0);
        chk({name, "_done"}, cfg_done, exp_done);
        chk({name, "_err"}, cfg_err, exp_err);
        if (exp_err) chk({name, "_err_index"}, err_index, exp_eidx);
    endtask

    function automatic int count_w(input logic [39:0] w);
        int c = 0;
        foreach (wlog[k]) if (wlog[k] == w) c++;
        return c;
    endfunction

    // Engine BFM: answers each transaction with the next planned response after
    // a random number of steps; response 2 means never raise i2c_end.
    initial begin : bfm
        int  resp = 0;
        int  lat = 0;
        int  steps = 0;
        bit  active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                i2c_end = 1'b0; ack = 1'b0; active = 1'b0;
            end else if (!active) begin
                if (trans) begin
                    resp   = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                    lat    = $urandom_range(1, 4);
                    steps  = 0;
                    active = 1'b1;
                end
            end else if (!i2c_end) begin
                if (!trans) active = 1'b0;
                else begin
                    if (i2c_en) steps++;
                    if (steps >= lat && resp != 2) begin
                        i2c_end = 1'b1; ack = (resp == 1);
                    end
                end
            end else if (!trans) begin
                i2c_end = 1'b0; ack = 1'b0; active = 1'b0;
            end
        end
    end

    // Per-cycle compare against the step timing rules and the expected write sequence.
    initial begin : monitor
        longint      last_en = -1;
        longint      rel_cyc = 0;
        longint      fall_cyc = 0;
        longint      d;
        bit          have_fall = 1'b0;
        bit          prev_trans = 1'b0;
        logic [39:0] cur_w = '0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("wr_high", wr, 1);
            if (rst) begin
                last_en = -1; rel_cyc = cyc; have_fall = 1'b0; prev_trans = 1'b0;
                continue;
            end
            if (last_en < 0 && i2c_en) last_en = cyc;
            if (last_en >= 0) begin
                d = (cyc - last_en) % CLK_DIV;
                chk("i2c_en_period", i2c_en, d == 0);
                chk("i2c_clk_phase", i2c_clk, (d >= CLK_DIV / 4) && (d < (3 * CLK_DIV) / 4));
            end
            if (cyc - rel_cyc == 2 * CLK_DIV) chk("en_after_reset", last_en >= 0, 1);
            if (trans && !prev_trans) begin
                chk("busy_at_trans", cfg_busy, 1);
                if (exp_q.size() == 0) chk("trans_with_empty_model", trans, 0);
                else chk("wdata_at_trans", i2c_wdata, exp_q.pop_front());
                cur_w = i2c_wdata;
                wlog.push_back(i2c_wdata);
                rise_cyc.push_back(cyc);
                if (have_fall) gap_log.push_back(cyc - fall_cyc);
            end else if (trans) begin
                chk("wdata_stable", i2c_wdata, cur_w);
            end else if (prev_trans) begin
                fall_cyc = cyc; have_fall = 1'b1;
            end
            prev_trans = trans;
        end
    end

    initial begin : main
        longint rel, st;
        int     w;
        clear_plan();
        load_spec_rom();

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_lut_index", lut_index, 0);
        chk("rst_i2c_en", i2c_en, 0);
        chk("rst_i2c_clk", i2c_clk, 0);
        chk("rst_wdata", i2c_wdata, 0);
        chk("rst_trans", trans, 0);
        chk("rst_busy", cfg_busy, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_err_index", err_index, 0);

        // Spec table, all acknowledged
        build_model();
        rel = cyc;
        rst = 1'b0;
        wait_idle("spec", 4000);
        check_end("spec");
        chk("spec_err_index", err_index, 0);
        chk("spec_busy", cfg_busy, 0);
        chk("spec_writes", wlog.size(), 3);
        if (wlog.size() >= 3) begin
            chk("spec_w0", wlog[0], 40'h79_78_3008_82);
            chk("spec_w1", wlog[1], 40'h79_78_3103_11);
            chk("spec_w2", wlog[2], 40'h79_78_4300_30);
        end
        if (rise_cyc.size() > 0) chk("init_quiet", rise_cyc[0] - rel >= INIT_DELAY, 1);
        if (gap_log.size() > 0) chk("delay_silence", gap_log[0] >= 2 * DLY_UNIT, 1);

        // Restart after DONE: no power-up delay
        build_model();
        st = cyc;
        pulse_start();
        chk("restart_done_clr", cfg_done, 0);
        chk("restart_busy", cfg_busy, 1);
        wait_idle("restart", 4000);
        check_end("restart");
        if (rise_cyc.size() > 0) chk("restart_no_init", rise_cyc[0] - st <= CLK_DIV, 1);

        // Entry 2 NACKed twice
        clear_plan();
        nack[2] = 2;
        build_model();
        pulse_start();
        wait_idle("nack2", 4000);
        check_end("nack2");
        chk("nack2_attempts", count_w(40'h79_78_3103_11), 3);

        // Entry 1 NACKed always
        clear_plan();
        rom[1] = 24'h3820_05;
        nack[1] = MAX_RETRY + 1;
        build_model();
        pulse_start();
        wait_idle("nack1", 4000);
        repeat (50) @(negedge clk);
        check_end("nack1");
        chk("nack1_attempts", count_w(40'h79_78_3820_05), 4);
        chk("nack1_err_index", err_index, 1);
        chk("nack1_busy", cfg_busy, 0);
        chk("nack1_done", cfg_done, 0);

        // Engine hangs on first attempt of entry 0, then acknowledges
        clear_plan();
        load_spec_rom();
        nack[0] = 1; hang[0] = 1'b1;
        build_model();
        pulse_start();
        wait_idle("hang", 4000);
        check_end("hang");
        if (rise_cyc.size() >= 2) begin
            chk("timeout_lo", rise_cyc[1] - rise_cyc[0] >= (TIMEOUT_STEPS - 1) * CLK_DIV, 1);
            chk("timeout_hi", rise_cyc[1] - rise_cyc[0] <= (TIMEOUT_STEPS + 3) * CLK_DIV, 1);
        end

        // Reset in the middle of a transfer
        nack[0] = MAX_RETRY + 1;
        build_model();
        pulse_start();
        w = 0;
        while (!trans && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("midxfer_trans_seen", trans, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midxfer_trans_clr", trans, 0);
        chk("midxfer_busy", cfg_busy, 1);
        @(negedge clk);
        clear_plan();
        build_model();
        rel = cyc;
        rst = 1'b0;
        wait_idle("midxfer", 4000);
        check_end("midxfer");
        if (rise_cyc.size() > 0) chk("midxfer_init_quiet", rise_cyc[0] - rel >= INIT_DELAY, 1);

        // Randomized tables and response plans
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < LUT_SIZE; i++) begin
                if ($urandom_range(0, 3) == 0) rom[i] = {16'hFFFF, 8'($urandom_range(0, 5))};
                else begin
                    rom[i] = 24'($urandom);
                    if (rom[i][23:8] == 16'hFFFF) rom[i][23:8] = 16'h3000;
                end
                w = $urandom_range(0, 9);
                nack[i] = (w < 6) ? 0 : (w < 8) ? 1 : (w < 9) ? 2 : MAX_RETRY + 1;
                hang[i] = (nack[i] == 1) && ($urandom_range(0, 3) == 0);
            end
            if (it % 2 == 0) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                build_model();
                rst = 1'b0;
            end else begin
                build_model();
                pulse_start();
            end
            repeat ($urandom_range(5, 60)) @(negedge clk);
            if (cfg_busy) pulse_start();
            wait_idle("rand", 8000);
            check_end("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
